// File: rtl/decode_stage.sv
// RV32I/M instruction-decode stage: combinational decode on the input side,
// registered into a two-entry skid buffer (main + skid) feeding execute.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit EN_MEXT  = 1'b1,
  parameter bit EN_FENCE = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INS,
  input  logic [XLEN-1:0] IN_PC,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_PC,
  output logic [31:0]     OUT_INS,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [2:0]      CS_TYPE,
  output logic            CS_JUMP,
  output logic            CS_JUMPR,
  output logic            CS_BRANCH,
  output logic [4:0]      CS_ALUOP,
  output logic            CS_ALUSRC1,
  output logic            CS_ALUSRC2,
  output logic            CS_MEMRD,
  output logic            CS_MEMWRT,
  output logic [2:0]      CS_MEMSZ,
  output logic            CS_M2R,
  output logic            CS_WRTSRC,
  output logic            CS_REGWRT,
  output logic            CS_ILLEGAL
);

  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            jump;
    logic            jumpr;
    logic            branch;
    logic [4:0]      aluop;
    logic            src1;
    logic            src2;
    logic            memrd;
    logic            memwrt;
    logic [2:0]      memsz;
    logic            m2r;
    logic            wrtsrc;
    logic            regwrt;
    logic            illegal;
  } bundle_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] sv;
    sv = v;
    return XLEN'(sv);
  endfunction

  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  bundle_t         w_dec_p0;
  logic            w_accept;

  assign w_opcode = IN_INS[6:0];
  assign w_f3     = IN_INS[14:12];
  assign w_f7     = IN_INS[31:25];
  assign w_rd     = IN_INS[11:7];
  assign w_imm_i  = sext32({{20{IN_INS[31]}}, IN_INS[31:20]});
  assign w_imm_s  = sext32({{20{IN_INS[31]}}, IN_INS[31:25], IN_INS[11:7]});
  assign w_imm_b  = sext32({{19{IN_INS[31]}}, IN_INS[31], IN_INS[7], IN_INS[30:25],
                            IN_INS[11:8], 1'b0});
  assign w_imm_u  = sext32({IN_INS[31:12], 12'b0});
  assign w_imm_j  = sext32({{11{IN_INS[31]}}, IN_INS[31], IN_INS[19:12], IN_INS[20],
                            IN_INS[30:21], 1'b0});

  // Stage p0: decode of the instruction presented at the input
  always_comb begin
    bundle_t d;
    logic    ill;
    d   = '0;
    ill = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        d.typ = TYPE_U; d.aluop = {1'b0, ALU_PASSB};
        d.src2 = 1'b1; d.wrtsrc = 1'b1; d.regwrt = 1'b1;
      end
      OP_AUIPC: begin
        d.typ = TYPE_U; d.aluop = {1'b0, ALU_ADD};
        d.src1 = 1'b1; d.src2 = 1'b1; d.wrtsrc = 1'b1; d.regwrt = 1'b1;
      end
      OP_JAL: begin
        d.typ = TYPE_J; d.jump = 1'b1; d.aluop = {1'b0, ALU_ADD};
        d.src1 = 1'b1; d.src2 = 1'b1; d.regwrt = 1'b1;
      end
      OP_JALR: begin
        if (w_f3 != 3'b000) ill = 1'b1;
        d.typ = TYPE_I; d.jumpr = 1'b1; d.aluop = {1'b0, ALU_ADD};
        d.src2 = 1'b1; d.regwrt = 1'b1;
      end
      OP_BRANCH: begin
        d.typ = TYPE_B; d.branch = 1'b1;
        case (w_f3)
          3'b000, 3'b001: d.aluop = {1'b0, ALU_SUB};
          3'b100, 3'b101: d.aluop = {1'b0, ALU_SLT};
          3'b110, 3'b111: d.aluop = {1'b0, ALU_SLTU};
          default:        ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) ill = 1'b1;
        d.typ = TYPE_I; d.memrd = 1'b1; d.m2r = 1'b1; d.memsz = w_f3;
        d.aluop = {1'b0, ALU_ADD}; d.src2 = 1'b1; d.wrtsrc = 1'b1; d.regwrt = 1'b1;
      end
      OP_STORE: begin
        if (w_f3[2] || w_f3 == 3'b011) ill = 1'b1;
        d.typ = TYPE_S; d.memwrt = 1'b1; d.memsz = w_f3;
        d.aluop = {1'b0, ALU_ADD}; d.src2 = 1'b1;
      end
      OP_IMM: begin
        d.typ = TYPE_I; d.src2 = 1'b1; d.wrtsrc = 1'b1; d.regwrt = 1'b1;
        d.aluop = {1'b0, alu_base(w_f3)};
        // Shift-immediates reuse imm[11:5] as a funct7 qualifier
        if (w_f3 == 3'b001 && w_f7 != F7_BASE) ill = 1'b1;
        if (w_f3 == 3'b101) begin
          if (w_f7 == F7_ALT)       d.aluop = {1'b0, ALU_SRA};
          else if (w_f7 != F7_BASE) ill = 1'b1;
        end
      end
      OP_REG: begin
        d.typ = TYPE_R; d.wrtsrc = 1'b1; d.regwrt = 1'b1;
        if (w_f7 == F7_BASE) begin
          d.aluop = {1'b0, alu_base(w_f3)};
        end else if (w_f7 == F7_ALT) begin
          if (w_f3 == 3'b000)      d.aluop = {1'b0, ALU_SUB};
          else if (w_f3 == 3'b101) d.aluop = {1'b0, ALU_SRA};
          else                     ill = 1'b1;
        end else if (w_f7 == F7_MEXT && EN_MEXT) begin
          d.aluop = {2'b10, w_f3};
        end else begin
          ill = 1'b1;
        end
      end
      OP_FENCE: begin
        if (!EN_FENCE) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase

    case (d.typ)
      TYPE_I:  d.imm = w_imm_i;
      TYPE_S:  d.imm = w_imm_s;
      TYPE_B:  d.imm = w_imm_b;
      TYPE_U:  d.imm = w_imm_u;
      TYPE_J:  d.imm = w_imm_j;
      default: d.imm = '0;
    endcase
    d.regwrt = d.regwrt & (w_rd != 5'd0);

    if (ill) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    d.pc     = IN_PC;
    d.ins    = IN_INS;
    w_dec_p0 = d;
  end

  bundle_t r_main_p1;
  bundle_t r_skid_p1;
  logic    r_vld_p1;
  logic    r_skid_vld_p1;

  assign IN_READY = !r_skid_vld_p1 && !RST;
  assign w_accept = IN_VALID && IN_READY;

  // Stage p1: main/skid registers; main always drives the outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_main_p1     <= '0;
    end else if (FLUSH) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (!r_vld_p1 || OUT_READY) begin
      if (r_skid_vld_p1) begin
        r_main_p1     <= r_skid_p1;
        r_vld_p1      <= 1'b1;
        r_skid_vld_p1 <= w_accept;
        if (w_accept) r_skid_p1 <= w_dec_p0;
      end else begin
        r_vld_p1 <= w_accept;
        if (w_accept) r_main_p1 <= w_dec_p0;
      end
    end else if (w_accept) begin
      r_skid_p1     <= w_dec_p0;
      r_skid_vld_p1 <= 1'b1;
    end
  end

  assign OUT_VALID  = r_vld_p1;
  assign OUT_PC     = r_main_p1.pc;
  assign OUT_INS    = r_main_p1.ins;
  assign OUT_IMM    = r_main_p1.imm;
  assign CS_TYPE    = r_main_p1.typ;
  assign CS_JUMP    = r_main_p1.jump;
  assign CS_JUMPR   = r_main_p1.jumpr;
  assign CS_BRANCH  = r_main_p1.branch;
  assign CS_ALUOP   = r_main_p1.aluop;
  assign CS_ALUSRC1 = r_main_p1.src1;
  assign CS_ALUSRC2 = r_main_p1.src2;
  assign CS_MEMRD   = r_main_p1.memrd;
  assign CS_MEMWRT  = r_main_p1.memwrt;
  assign CS_MEMSZ   = r_main_p1.memsz;
  assign CS_M2R     = r_main_p1.m2r;
  assign CS_WRTSRC  = r_main_p1.wrtsrc;
  assign CS_REGWRT  = r_main_p1.regwrt;
  assign CS_ILLEGAL = r_main_p1.illegal;

endmodule
